// File: rtl/acum_datapath.sv
// Fixed-point sequenced multiply-accumulate evaluator (Q(WIDTH-FRAC).FRAC); define ACUM_SAT_EN to saturate instead of wrap.
// Latency: start -> PREP -> RUN (one acc update per cycle) -> DONE on band_listo rising edge; no backpressure, y_valid is a one-cycle pulse.
module acum_datapath #(
    parameter int               WIDTH = 16,
    parameter int               FRAC  = 8,
    parameter logic [WIDTH-1:0] C0    = 16'h0100,
    parameter logic [WIDTH-1:0] C1    = 16'h0200,
    parameter logic [WIDTH-1:0] C2    = 16'h0080,
    parameter logic [WIDTH-1:0] C3    = 16'h0040,
    parameter logic [WIDTH-1:0] C4    = 16'h0020,
    parameter logic [WIDTH-1:0] C5    = 16'h0010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [2:0]       sel_const,
    input  logic [1:0]       sel_fun,
    input  logic [1:0]       sel_acum,
    input  logic             senal,
    input  logic             band_listo,
    output logic [WIDTH-1:0] y_out,
    output logic             y_valid,
    output logic             busy,
    output logic             ovf
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_reg_q, x_reg_d;
    logic [WIDTH-1:0] xsq_q, xsq_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] temp_q, temp_d;
    logic [WIDTH-1:0] y_out_q, y_out_d;
    logic             ovf_q, ovf_d;
    logic             band_prev_q, band_prev_d;

    logic [WIDTH-1:0]        k_val;
    logic [WIDTH-1:0]        op_val;
    logic signed [PW-1:0]    xsq_full;
    logic signed [PW-1:0]    prod_full;
    logic signed [PW-1:0]    sum_full;
    logic [WIDTH:0]          xsq_lim;
    logic [WIDTH:0]          p_lim;
    logic [WIDTH:0]          sum_lim;
    logic                    band_rise;

    // Returns {overflow, limited value} for a sign-extended wide result.
    function automatic logic [WIDTH:0] lim(input logic signed [PW-1:0] v);
        logic fits;
        fits = (v[PW-1:WIDTH-1] == {(WIDTH+1){v[WIDTH-1]}});
`ifdef ACUM_SAT_EN
        if (fits)
            lim = {1'b0, v[WIDTH-1:0]};
        else if (v[PW-1])
            lim = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        else
            lim = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
`else
        lim = {~fits, v[WIDTH-1:0]};
`endif
    endfunction

    always_comb begin
        k_val = '0;
        case (sel_const)
            3'd0:    k_val = C0;
            3'd1:    k_val = C1;
            3'd2:    k_val = C2;
            3'd3:    k_val = C3;
            3'd4:    k_val = C4;
            3'd5:    k_val = C5;
            default: k_val = '0;
        endcase
    end

    // temp forwards the accumulator when senal latches it this same cycle.
    always_comb begin
        op_val = '0;
        case (sel_fun)
            2'b00:   op_val = x_reg_q;
            2'b01:   op_val = xsq_q;
            2'b10:   op_val = senal ? acc_q : temp_q;
            default: op_val[FRAC] = 1'b1;
        endcase
    end

    always_comb begin
        xsq_full  = $signed({{WIDTH{x_reg_q[WIDTH-1]}}, x_reg_q})
                  * $signed({{WIDTH{x_reg_q[WIDTH-1]}}, x_reg_q});
        xsq_full  = xsq_full >>> FRAC;
        xsq_lim   = lim(xsq_full);
        prod_full = $signed({{WIDTH{k_val[WIDTH-1]}}, k_val})
                  * $signed({{WIDTH{op_val[WIDTH-1]}}, op_val});
        prod_full = prod_full >>> FRAC;
        p_lim     = lim(prod_full);
        sum_full  = $signed({{WIDTH{acc_q[WIDTH-1]}}, acc_q})
                  + $signed({{WIDTH{p_lim[WIDTH-1]}}, p_lim[WIDTH-1:0]});
        sum_lim   = lim(sum_full);
    end

    assign band_rise = band_listo & ~band_prev_q;

    always_comb begin
        state_d     = state_q;
        x_reg_d     = x_reg_q;
        xsq_d       = xsq_q;
        acc_d       = acc_q;
        temp_d      = temp_q;
        y_out_d     = y_out_q;
        ovf_d       = ovf_q;
        band_prev_d = band_listo;
        if (start) begin
            state_d = PREP;
            x_reg_d = x_in;
            acc_d   = '0;
            temp_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                PREP: begin
                    xsq_d   = xsq_lim[WIDTH-1:0];
                    ovf_d   = ovf_q | xsq_lim[WIDTH];
                    state_d = RUN;
                end
                RUN: begin
                    case (sel_acum)
                        2'b00: begin
                            acc_d = p_lim[WIDTH-1:0];
                            ovf_d = ovf_q | p_lim[WIDTH];
                        end
                        2'b01: begin
                            acc_d = sum_lim[WIDTH-1:0];
                            ovf_d = ovf_q | p_lim[WIDTH] | sum_lim[WIDTH];
                        end
                        2'b11:   acc_d = '0;
                        default: acc_d = acc_q;
                    endcase
                    if (senal)
                        temp_d = acc_q;
                    if (band_rise) begin
                        state_d = DONE;
                        y_out_d = acc_d;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Edge history resets high so a level already asserted at release is not a completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x_reg_q     <= '0;
            xsq_q       <= '0;
            acc_q       <= '0;
            temp_q      <= '0;
            y_out_q     <= '0;
            ovf_q       <= 1'b0;
            band_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_reg_q     <= x_reg_d;
            xsq_q       <= xsq_d;
            acc_q       <= acc_d;
            temp_q      <= temp_d;
            y_out_q     <= y_out_d;
            ovf_q       <= ovf_d;
            band_prev_q <= band_prev_d;
        end
    end

    assign y_out   = y_out_q;
    assign y_valid = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_acum_datapath.sv
// Directed bench for acum_datapath; expected values are hand-computed Q8.8 results.
module tb_acum_datapath;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] x_in;
    logic [2:0]  sel_const;
    logic [1:0]  sel_fun;
    logic [1:0]  sel_acum;
    logic        senal;
    logic        band_listo;
    logic [15:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    logic [2:0] sc [8];
    logic [1:0] sf [8];
    logic [1:0] sa [8];
    logic       ss [8];

    acum_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x_in       (x_in),
        .sel_const  (sel_const),
        .sel_fun    (sel_fun),
        .sel_acum   (sel_acum),
        .senal      (senal),
        .band_listo (band_listo),
        .y_out      (y_out),
        .y_valid    (y_valid),
        .busy       (busy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_step(input int i, input logic [2:0] c, input logic [1:0] f,
                            input logic [1:0] a, input logic s);
        sc[i] = c; sf[i] = f; sa[i] = a; ss[i] = s;
    endtask

    // Start, PREP, n RUN steps, then raise band_listo; returns sampled in DONE.
    task automatic run_seq(input logic [15:0] x, input int n);
        start = 1'b1; x_in = x;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            sel_const = sc[i]; sel_fun = sf[i]; sel_acum = sa[i]; senal = ss[i];
            tick();
        end
        sel_acum = 2'b10; senal = 1'b0; band_listo = 1'b1;
        tick();
    endtask

    task automatic finish_run();
        band_listo = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; x_in = '0; sel_const = '0; sel_fun = '0;
        sel_acum = 2'b10; senal = 1'b0; band_listo = 1'b0;
        repeat (3) tick();
        total++; if (y_out !== 16'h0000) begin bad++; $display("FAIL rst_y: got %h want 0000", y_out); end
        total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", y_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        set_step(0, 3'd0, 2'b11, 2'b00, 1'b0);
        set_step(1, 3'd1, 2'b00, 2'b01, 1'b0);
        set_step(2, 3'd2, 2'b10, 2'b01, 1'b0);
        start = 1'b1; x_in = 16'h0200;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_prep: got %b want 1", busy); end
        tick();
        for (int i = 0; i < 3; i++) begin
            sel_const = sc[i]; sel_fun = sf[i]; sel_acum = sa[i]; senal = ss[i];
            tick();
            total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", y_valid); end
        end
        sel_acum = 2'b10; band_listo = 1'b1;
        tick();
        total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", y_valid); end
        total++; if (y_out !== 16'h0500) begin bad++; $display("FAIL basic_y: got %h want 0500", y_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_done: got %b want 1", busy); end
        tick();
        total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %b want 0", y_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
        // band_listo still high in IDLE and selects wiggling must change nothing
        sel_acum = 2'b11; senal = 1'b1; sel_const = 3'd5;
        repeat (3) tick();
        total++; if (y_out !== 16'h0500) begin bad++; $display("FAIL idle_hold_y: got %h want 0500", y_out); end
        total++; if (y_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_quiet: got valid=%b busy=%b want 0 0", y_valid, busy); end
        sel_acum = 2'b10; senal = 1'b0;
        finish_run();
    endtask

    task automatic test_temp();
        set_step(0, 3'd1, 2'b01, 2'b00, 1'b0);
        run_seq(16'h0200, 1);
        total++; if (y_out !== 16'h0800) begin bad++; $display("FAIL sq_y: got %h want 0800", y_out); end
        finish_run();
        set_step(1, 3'd0, 2'b10, 2'b01, 1'b1);
        run_seq(16'h0200, 2);
        total++; if (y_out !== 16'h1000) begin bad++; $display("FAIL senal_acc: got %h want 1000", y_out); end
        finish_run();
        set_step(2, 3'd0, 2'b10, 2'b00, 1'b0);
        run_seq(16'h0200, 3);
        total++; if (y_out !== 16'h0800) begin bad++; $display("FAIL temp_val: got %h want 0800", y_out); end
        finish_run();
    endtask

    task automatic test_overflow();
        logic [15:0] exp_pos;
        logic [15:0] exp_neg;
`ifdef ACUM_SAT_EN
        exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
        exp_pos = 16'hFE00; exp_neg = 16'h0200;
`endif
        set_step(0, 3'd1, 2'b00, 2'b01, 1'b0);
        run_seq(16'h7F00, 1);
        total++; if (y_out !== exp_pos) begin bad++; $display("FAIL ovf_pos_y: got %h want %h", y_out, exp_pos); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_pos_flag: got %b want 1", ovf); end
        finish_run();
        run_seq(16'h8100, 1);
        total++; if (y_out !== exp_neg) begin bad++; $display("FAIL ovf_neg_y: got %h want %h", y_out, exp_neg); end
        finish_run();
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        start = 1'b1; x_in = 16'h0100;
        tick();
        start = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        tick();
        band_listo = 1'b1;
        tick();
        finish_run();
    endtask

    task automatic test_const_clear();
        set_step(0, 3'd0, 2'b11, 2'b00, 1'b0);
        set_step(1, 3'd6, 2'b00, 2'b01, 1'b0);
        set_step(2, 3'd7, 2'b11, 2'b01, 1'b0);
        run_seq(16'h0200, 3);
        total++; if (y_out !== 16'h0100) begin bad++; $display("FAIL k67_zero: got %h want 0100", y_out); end
        finish_run();
        set_step(1, 3'd0, 2'b00, 2'b11, 1'b0);
        run_seq(16'h0200, 2);
        total++; if (y_out !== 16'h0000) begin bad++; $display("FAIL acc_clear: got %h want 0000", y_out); end
        finish_run();
        set_step(0, 3'd3, 2'b00, 2'b00, 1'b0);
        set_step(1, 3'd4, 2'b11, 2'b01, 1'b0);
        set_step(2, 3'd5, 2'b11, 2'b01, 1'b0);
        run_seq(16'h0200, 3);
        total++; if (y_out !== 16'h00B0) begin bad++; $display("FAIL k345_sum: got %h want 00b0", y_out); end
        finish_run();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; x_in = 16'h7F00;
        tick();
        start = 1'b0;
        tick();
        sel_const = 3'd0; sel_fun = 2'b11; sel_acum = 2'b00;
        tick();
        sel_acum = 2'b10;
        total++; if (ovf !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_pre: got ovf=%b busy=%b want 1 1", ovf, busy); end
        #2 reset = 1'b1;
        #1;
        total++; if (y_out !== 16'h0000) begin bad++; $display("FAIL mid_rst_y: got %h want 0000", y_out); end
        total++; if (busy !== 1'b0 || ovf !== 1'b0 || y_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got busy=%b ovf=%b valid=%b want 0 0 0", busy, ovf, y_valid); end
        band_listo = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (y_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_no_valid: got valid=%b busy=%b want 0 0", y_valid, busy); end
        end
        band_listo = 1'b0;
        tick();
    endtask

    task automatic test_start_beats_band();
        set_step(0, 3'd0, 2'b11, 2'b00, 1'b0);
        set_step(1, 3'd1, 2'b00, 2'b01, 1'b0);
        run_seq(16'h0200, 2);
        total++; if (y_out !== 16'h0500) begin bad++; $display("FAIL race_setup: got %h want 0500", y_out); end
        finish_run();
        start = 1'b1; x_in = 16'h0100;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1; x_in = 16'h0300; band_listo = 1'b1;
        tick();
        start = 1'b0;
        total++; if (y_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL race_prep: got valid=%b busy=%b want 0 1", y_valid, busy); end
        total++; if (y_out !== 16'h0500) begin bad++; $display("FAIL race_y_held: got %h want 0500", y_out); end
        tick();
        sel_const = 3'd0; sel_fun = 2'b00; sel_acum = 2'b00;
        tick();
        sel_acum = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL race_level: got %b want 0", y_valid); end
        end
        band_listo = 1'b0;
        tick();
        band_listo = 1'b1;
        tick();
        total++; if (y_valid !== 1'b1 || y_out !== 16'h0300) begin bad++; $display("FAIL race_done: got valid=%b y=%h want 1 0300", y_valid, y_out); end
        finish_run();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_temp();
        test_overflow();
        test_const_clear();
        test_start_beats_band();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acum_datapath.md
ACUM_DATAPATH -- requirements
Module: acum_datapath

Interface
REQ-001 Parameter WIDTH, 16, operand/result width, signed two's complement.
REQ-002 Parameter FRAC, 8, fractional bits (Q8.8 at default).
REQ-003 Parameters C0..C5, 16'h0100/16'h0200/16'h0080/16'h0040/16'h0020/16'h0010, constant table entries.
REQ-004 clk  input  1  single clock; all registers on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request: capture x_in and begin an evaluation.
REQ-007 x_in  input  WIDTH  signed operand, sampled only when start=1.
REQ-008 sel_const  input  3  constant select from the sequencer.
REQ-009 sel_fun  input  2  operand select from the sequencer.
REQ-010 sel_acum  input  2  accumulator operation select from the sequencer.
REQ-011 senal  input  1  latch accumulator into temp register.
REQ-012 band_listo  input  1  sequencer done flag (level; may stay high).
REQ-013 y_out  output  WIDTH  result, held until next completion.
REQ-014 y_valid  output  1  one-cycle pulse when y_out updates.
REQ-015 busy  output  1  high from cycle after start until y_valid cycle inclusive.
REQ-016 ovf  output  1  sticky overflow flag, cleared by start.

Function
REQ-017 FSM states SHALL be IDLE, PREP, RUN, DONE; IDLE->PREP on start; PREP->RUN unconditionally; RUN->DONE on band_listo=1 while band_listo was 0 previous cycle; DONE->IDLE unconditionally.
REQ-018 On start (any state) SHALL capture x_reg<=x_in, clear acc, temp, ovf, and go to PREP; start beats band_listo and senal in the same cycle.
REQ-019 PREP SHALL compute xsq_reg = (x_reg*x_reg)>>>FRAC (rounded toward minus infinity, range-limited per REQ-024); selects ignored in PREP.
REQ-020 Constant K = C[sel_const] for 0..5; sel_const 6 or 7 SHALL give K=0.
REQ-021 Operand OP: sel_fun 00=x_reg, 01=xsq_reg, 10=temp, 11=1.0 (1<<FRAC).
REQ-022 Product P = (K*OP) as 2*WIDTH signed, arithmetic shift right FRAC, then range-limited per REQ-024.
REQ-023 In RUN only, each edge: sel_acum 00 acc<=P; 01 acc<=acc+P (range-limited); 10 hold; 11 acc<=0; latency one cycle from select to acc.
REQ-024 Range limiting per Configuration section; any limited or wrapped result SHALL set ovf.
REQ-025 senal=1 in RUN SHALL set temp<=acc (pre-update value); acc update same cycle still applies.
REQ-026 Entering DONE SHALL load y_out<=acc (value after last RUN update) and assert y_valid for exactly that cycle.
REQ-027 band_listo held high after DONE SHALL NOT retrigger; a new rising edge is required in a new RUN.
REQ-028 In IDLE, sel_*/senal/band_listo SHALL have no effect on any register.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, x_reg, xsq_reg, acc, temp, y_out=0, y_valid=0, busy=0, ovf=0, including mid-evaluation; no y_valid follows an aborted run.
REQ-030 Band-listo edge detector history SHALL reset to 1 so a level already high at release does not complete.

Configuration
REQ-031 Macro ACUM_SAT_EN defined: results saturate to 0x7FFF / 0x8000 and set ovf.
REQ-032 Macro ACUM_SAT_EN undefined: results wrap modulo 2^WIDTH, ovf set on signed overflow detection; no saturation logic.

Verification
REQ-033 x_in=0x0200, start; RUN selects (c0,f11,a00),(c1,f00,a01),(c2,f10,a01), then band_listo -> y_out=0x0500, y_valid one cycle, ovf=0.
REQ-034 x_in=0x0200; (c1,f01,a00) -> acc=0x0800 (2.0*4.0); senal with (c0,f10,a01) -> temp=0x0800, acc=0x1000.
REQ-035 With ACUM_SAT_EN, x_in=0x7F00, (c1,f00,a01) -> acc=0x7FFF, ovf=1; without macro -> acc=0xFE00, ovf=1.
REQ-036 sel_const=6 with any sel_fun, a01 -> acc unchanged; sel_acum=11 -> acc=0.
REQ-037 reset pulsed mid-RUN -> all outputs 0 asynchronously, later band_listo high -> no y_valid.
REQ-038 start and band_listo rising in same cycle -> PREP entered, no y_valid, y_out unchanged.
